// File: rtl/up_dn_counter_pkg.sv
// rtl/up_dn_counter_pkg.sv - shared types and elaboration helpers for the up/down counter
package up_dn_counter_pkg;

  typedef enum logic {
    UDC_SAT  = 1'b0,
    UDC_WRAP = 1'b1
  } udc_mode_e;

  // Number of distinct values in [min_v, max_v]; the wrap offset.
  function automatic int udc_range(input int min_v, input int max_v);
    return max_v - min_v + 1;
  endfunction

  function automatic int udc_clamp(input int v, input int min_v, input int max_v);
    if (v < min_v) return min_v;
    if (v > max_v) return max_v;
    return v;
  endfunction

endpackage

// File: rtl/udc_next_calc.sv
// rtl/udc_next_calc.sv - combinational next-count for one up/down step with wrap or clamp
module udc_next_calc
  import up_dn_counter_pkg::*;
#(
  parameter int               WIDTH   = 5,
  parameter int               STEP_W  = 3,
  parameter logic [WIDTH-1:0] MIN_VAL = '0,
  parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
  input  logic [WIDTH-1:0]  count,
  input  logic              up,
  input  logic              down,
  input  logic [STEP_W-1:0] step,
  input  udc_mode_e         mode,
  output logic [WIDTH-1:0]  next_count,
  output logic              wrap,
  output logic              sat
);

  // Signed headroom so count-step can go below MIN (or zero) without aliasing.
  localparam int XW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 2;

  localparam logic signed [XW-1:0] MIN_X   = XW'(MIN_VAL);
  localparam logic signed [XW-1:0] MAX_X   = XW'(MAX_VAL);
  localparam logic signed [XW-1:0] RANGE_X = XW'(udc_range(int'(MIN_VAL), int'(MAX_VAL)));

  logic signed [XW-1:0] cnt_x;
  logic signed [XW-1:0] step_x;
  logic signed [XW-1:0] t_up;
  logic signed [XW-1:0] t_dn;

  assign cnt_x  = XW'(count);
  assign step_x = XW'(step);
  assign t_up   = cnt_x + step_x;
  assign t_dn   = cnt_x - step_x;

  always_comb begin
    next_count = count;
    wrap       = 1'b0;
    sat        = 1'b0;
    if (step != '0) begin
      if (down) begin
        if (t_dn >= MIN_X) begin
          next_count = WIDTH'(t_dn);
        end else if (mode == UDC_WRAP) begin
          next_count = WIDTH'(t_dn + RANGE_X);
          wrap       = 1'b1;
        end else begin
          next_count = MIN_VAL;
          sat        = 1'b1;
        end
      end else if (up) begin
        if (t_up <= MAX_X) begin
          next_count = WIDTH'(t_up);
        end else if (mode == UDC_WRAP) begin
          next_count = WIDTH'(t_up - RANGE_X);
          wrap       = 1'b1;
        end else begin
          next_count = MAX_VAL;
          sat        = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/up_dn_counter_param.sv
// rtl/up_dn_counter_param.sv - bounded up/down counter with step, saturate/wrap mode and load clamp
// Optional sticky overflow/underflow flags are built when UDC_STICKY_EN is defined.
module up_dn_counter_param
  import up_dn_counter_pkg::*;
#(
  parameter int               WIDTH   = 5,
  parameter int               STEP_W  = 3,
  parameter logic [WIDTH-1:0] MIN_VAL = '0,
  parameter logic [WIDTH-1:0] MAX_VAL = '1,
  parameter logic [WIDTH-1:0] RST_VAL = MIN_VAL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WIDTH-1:0]  in_val,
  input  logic              up,
  input  logic              down,
  input  logic [STEP_W-1:0] step,
  input  udc_mode_e         mode,
`ifdef UDC_STICKY_EN
  input  logic              clr_sticky,
  output logic              ovf_sticky,
  output logic              unf_sticky,
`endif
  output logic [WIDTH-1:0]  count,
  output logic              high,
  output logic              low,
  output logic              wrap_p,
  output logic              sat_p,
  output logic              load_err_p
);

  logic [WIDTH-1:0] calc_count;
  logic             calc_wrap;
  logic             calc_sat;
  logic [WIDTH-1:0] load_val;
  logic             load_oor;

  udc_next_calc #(
    .WIDTH   (WIDTH),
    .STEP_W  (STEP_W),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL)
  ) u_next_calc (
    .count      (count),
    .up         (up),
    .down       (down),
    .step       (step),
    .mode       (mode),
    .next_count (calc_count),
    .wrap       (calc_wrap),
    .sat        (calc_sat)
  );

  // An out-of-range load is detected by the clamp changing the value.
  assign load_val = WIDTH'(udc_clamp(int'(in_val), int'(MIN_VAL), int'(MAX_VAL)));
  assign load_oor = (load_val != in_val);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count      <= RST_VAL;
      wrap_p     <= 1'b0;
      sat_p      <= 1'b0;
      load_err_p <= 1'b0;
    end else if (load) begin
      count      <= load_val;
      wrap_p     <= 1'b0;
      sat_p      <= 1'b0;
      load_err_p <= load_oor;
    end else begin
      count      <= calc_count;
      wrap_p     <= calc_wrap;
      sat_p      <= calc_sat;
      load_err_p <= 1'b0;
    end
  end

  assign high = (count == MAX_VAL);
  assign low  = (count == MIN_VAL);

`ifdef UDC_STICKY_EN
  // down beats up, so any bound event while down is asserted is on the low side.
  logic ovf_set;
  logic unf_set;

  assign ovf_set = !load && !down && (calc_wrap || calc_sat);
  assign unf_set = !load &&  down && (calc_wrap || calc_sat);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      ovf_sticky <= ovf_set || (ovf_sticky && !clr_sticky);
      unf_sticky <= unf_set || (unf_sticky && !clr_sticky);
    end
  end
`endif

endmodule
